// File: rtl/sa_wdata_steer_pkg.sv
// Shared definitions for the slave-side write-data steering block: default
// geometry and the layouts of the order-FIFO and per-master queue entries.
package sa_wdata_steer_pkg;

    localparam int unsigned MstAmtDef         = 4;
    localparam int unsigned OutstandingAmtDef = 8;
    localparam int unsigned WdataFifoDepthDef = 16;
    localparam int unsigned DataWidthDef      = 32;
    localparam int unsigned TransDataLenWDef  = 8;

    // Order entry layout: {mst_id, len}, len in the low bits.
    function automatic int unsigned ord_entry_w(int unsigned id_w, int unsigned len_w);
        return id_w + len_w;
    endfunction

    // Queue entry layout: {data, strb, last}, last in bit 0.
    function automatic int unsigned q_entry_w(int unsigned data_w, int unsigned strb_w);
        return data_w + strb_w + 1;
    endfunction

endpackage

// File: rtl/sa_wdata_steer_fifo.sv
// Generic synchronous FIFO with a registered-pointer, combinational read port.
// A push while full is refused (no bypass); a pop while empty is ignored.
module sa_wdata_steer_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];

    // Pointers and occupancy; pointers wrap naturally since Depth is a power of 2.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            cnt_q <= cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sa_wdata_steer.sv
// Slave-side write-data steering: queues per-master W beats and forwards them
// to the slave in AW-grant order, with WLAST generated from the granted AxLEN.
module sa_wdata_steer
    import sa_wdata_steer_pkg::*;
#(
    parameter int unsigned MST_AMT          = MstAmtDef,
    parameter int unsigned MST_ID_W         = $clog2(MST_AMT),
    parameter int unsigned OUTSTANDING_AMT  = OutstandingAmtDef,
    parameter int unsigned WDATA_FIFO_DEPTH = WdataFifoDepthDef,
    parameter int unsigned DATA_WIDTH       = DataWidthDef,
    parameter int unsigned STRB_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned TRANS_DATA_LEN_W = TransDataLenWDef
) (
    input  logic                          ACLK_i,
    input  logic                          ARESETn_i,
    input  logic [DATA_WIDTH*MST_AMT-1:0] dsp_WDATA_i,
    input  logic [STRB_WIDTH*MST_AMT-1:0] dsp_WSTRB_i,
    input  logic [MST_AMT-1:0]            dsp_WLAST_i,
    input  logic [MST_AMT-1:0]            dsp_WVALID_i,
    input  logic [MST_AMT-1:0]            dsp_slv_sel_i,
    output logic [MST_AMT-1:0]            dsp_WREADY_o,
    input  logic [MST_ID_W-1:0]           AW_mst_id_i,
    input  logic [TRANS_DATA_LEN_W-1:0]   AW_AxLEN_i,
    input  logic                          AW_fifo_order_wr_en_i,
    output logic                          AW_stall_o,
    output logic [DATA_WIDTH-1:0]         s_WDATA_o,
    output logic [STRB_WIDTH-1:0]         s_WSTRB_o,
    output logic                          s_WLAST_o,
    output logic                          s_WVALID_o,
    input  logic                          s_WREADY_i,
    output logic                          wlast_err_o,
    output logic [MST_ID_W-1:0]           wlast_err_id_o
);

    localparam int unsigned QW = q_entry_w(DATA_WIDTH, STRB_WIDTH);
    localparam int unsigned OW = ord_entry_w(MST_ID_W, TRANS_DATA_LEN_W);

    logic [QW-1:0]               q_rdata [MST_AMT];
    logic [MST_AMT-1:0]          q_full, q_empty, q_push, q_pop;
    logic [OW-1:0]               ord_rdata;
    logic                        ord_full, ord_empty, ord_pop;
    logic [MST_ID_W-1:0]         head_id;
    logic [TRANS_DATA_LEN_W-1:0] head_len;
    logic [QW-1:0]               head_entry;
    logic                        head_empty;
    logic                        out_free, issue, last_due;
    logic [TRANS_DATA_LEN_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic [STRB_WIDTH-1:0]       wstrb_q;
    logic                        wlast_q, wvalid_q, err_q;
    logic [MST_ID_W-1:0]         err_id_q;

    // Per-master beat queues; a master not at the order head keeps enqueuing freely.
    for (genvar i = 0; i < MST_AMT; i++) begin : g_q
        assign q_push[i] = dsp_WVALID_i[i] & dsp_slv_sel_i[i] & ~q_full[i];

        sa_wdata_steer_fifo #(
            .Width(QW),
            .Depth(WDATA_FIFO_DEPTH)
        ) u_q (
            .clk_i  (ACLK_i),
            .rst_ni (ARESETn_i),
            .push_i (q_push[i]),
            .wdata_i({dsp_WDATA_i[i*DATA_WIDTH +: DATA_WIDTH],
                      dsp_WSTRB_i[i*STRB_WIDTH +: STRB_WIDTH],
                      dsp_WLAST_i[i]}),
            .pop_i  (q_pop[i]),
            .rdata_o(q_rdata[i]),
            .full_o (q_full[i]),
            .empty_o(q_empty[i])
        );
    end

    assign dsp_WREADY_o = ~q_full;

    sa_wdata_steer_fifo #(
        .Width(OW),
        .Depth(OUTSTANDING_AMT)
    ) u_order (
        .clk_i  (ACLK_i),
        .rst_ni (ARESETn_i),
        .push_i (AW_fifo_order_wr_en_i),
        .wdata_i({AW_mst_id_i, AW_AxLEN_i}),
        .pop_i  (ord_pop),
        .rdata_o(ord_rdata),
        .full_o (ord_full),
        .empty_o(ord_empty)
    );

    assign AW_stall_o = ord_full;
    assign head_id    = ord_rdata[OW-1 -: MST_ID_W];
    assign head_len   = ord_rdata[TRANS_DATA_LEN_W-1:0];

    // Select the queue of the master at the order head and decode per-queue pops.
    always_comb begin
        head_entry = '0;
        head_empty = 1'b1;
        q_pop      = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (head_id == MST_ID_W'(i)) begin
                head_entry = q_rdata[i];
                head_empty = q_empty[i];
                q_pop[i]   = issue;
            end
        end
    end

    assign out_free = ~wvalid_q | s_WREADY_i;
    assign issue    = ~ord_empty & ~head_empty & out_free;
    assign last_due = (cnt_q == head_len);
    // Retiring the head on its last beat lets the next burst issue on the very next cycle.
    assign ord_pop  = issue & last_due;

    // Beat counter within the current burst; reloads to 0 as the burst retires.
    always_comb begin
        cnt_d = cnt_q;
        if (issue) cnt_d = last_due ? '0 : cnt_q + TRANS_DATA_LEN_W'(1);
    end

    // Output register: loads on issue, clears on acceptance, otherwise holds.
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            cnt_q    <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wlast_q  <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (issue) begin
                wdata_q  <= head_entry[QW-1 -: DATA_WIDTH];
                wstrb_q  <= head_entry[STRB_WIDTH:1];
                wlast_q  <= last_due;
                wvalid_q <= 1'b1;
            end else if (s_WREADY_i) begin
                wvalid_q <= 1'b0;
            end
        end
    end

    // WLAST mismatch: master's own WLAST disagrees with the counted length.
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            err_q <= issue & (head_entry[0] != last_due);
            if (issue & (head_entry[0] != last_due)) err_id_q <= head_id;
        end
    end

    assign s_WDATA_o      = wdata_q;
    assign s_WSTRB_o      = wstrb_q;
    assign s_WLAST_o      = wlast_q;
    assign s_WVALID_o     = wvalid_q;
    assign wlast_err_o    = err_q;
    assign wlast_err_id_o = err_id_q;

endmodule

// File: tb/tb_sa_wdata_steer.sv
// Directed bench for sa_wdata_steer: ordering, latency, back-to-back bursts,
// backpressure, WLAST mismatch, queue/order-FIFO full and mid-burst reset.
module tb_sa_wdata_steer;

    localparam int unsigned MA  = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned LW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [MA*DW-1:0]  dsp_wdata;
    logic [MA*SW-1:0]  dsp_wstrb;
    logic [MA-1:0]     dsp_wlast, dsp_wvalid, dsp_sel, dsp_wready;
    logic [IDW-1:0]    aw_id;
    logic [LW-1:0]     aw_len;
    logic              aw_wr, aw_stall;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic              s_wlast, s_wvalid, s_wready;
    logic              wlast_err;
    logic [IDW-1:0]    err_id;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [DW-1:0]  mon_data [$];
    logic [SW-1:0]  mon_strb [$];
    logic           mon_last [$];
    int             mon_cyc  [$];
    logic [IDW-1:0] err_ids  [$];
    int             err_cyc  [$];

    sa_wdata_steer u_dut (
        .ACLK_i               (clk),
        .ARESETn_i            (rst_n),
        .dsp_WDATA_i          (dsp_wdata),
        .dsp_WSTRB_i          (dsp_wstrb),
        .dsp_WLAST_i          (dsp_wlast),
        .dsp_WVALID_i         (dsp_wvalid),
        .dsp_slv_sel_i        (dsp_sel),
        .dsp_WREADY_o         (dsp_wready),
        .AW_mst_id_i          (aw_id),
        .AW_AxLEN_i           (aw_len),
        .AW_fifo_order_wr_en_i(aw_wr),
        .AW_stall_o           (aw_stall),
        .s_WDATA_o            (s_wdata),
        .s_WSTRB_o            (s_wstrb),
        .s_WLAST_o            (s_wlast),
        .s_WVALID_o           (s_wvalid),
        .s_WREADY_i           (s_wready),
        .wlast_err_o          (wlast_err),
        .wlast_err_id_o       (err_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after a rising edge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        if (rst_n && s_wvalid && s_wready) begin
            mon_data.push_back(s_wdata);
            mon_strb.push_back(s_wstrb);
            mon_last.push_back(s_wlast);
            mon_cyc.push_back(cyc);
        end
        if (rst_n && wlast_err) begin
            err_ids.push_back(err_id);
            err_cyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_strb.delete();
        mon_last.delete();
        mon_cyc.delete();
        err_ids.delete();
        err_cyc.delete();
    endtask

    task automatic aw_push(input int id, input int len);
        aw_id  = IDW'(id);
        aw_len = LW'(len);
        aw_wr  = 1'b1;
        step();
        aw_wr  = 1'b0;
    endtask

    task automatic send_beat(input int m, input logic [DW-1:0] d, input logic l,
                             output int hs_cyc);
        int t = 0;
        while (!dsp_wready[m] && t < 50) begin
            step();
            t++;
        end
        check("wready_before_beat", 64'(dsp_wready[m]), 64'd1);
        dsp_wdata[m*DW +: DW] = d;
        dsp_wstrb[m*SW +: SW] = 4'hF;
        dsp_wlast[m]          = l;
        dsp_wvalid[m]         = 1'b1;
        dsp_sel[m]            = 1'b1;
        step();
        hs_cyc        = cyc;
        dsp_wvalid[m] = 1'b0;
        dsp_sel[m]    = 1'b0;
        dsp_wlast[m]  = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t = 0;
        while (mon_data.size() < n && t < 300) begin
            step();
            t++;
        end
        repeat (5) step();
        check({tag, "_beat_count"}, 64'(mon_data.size()), 64'(n));
    endtask

    int hs, hs0, aw_m, t;
    logic [DW-1:0] held;

    initial begin
        rst_n      = 1'b0;
        dsp_wdata  = '0;
        dsp_wstrb  = '0;
        dsp_wlast  = '0;
        dsp_wvalid = '0;
        dsp_sel    = '0;
        aw_id      = '0;
        aw_len     = '0;
        aw_wr      = 1'b0;
        s_wready   = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_wvalid", 64'(s_wvalid), 64'd0);
        check("rst_wlast", 64'(s_wlast), 64'd0);
        check("rst_wdata", 64'(s_wdata), 64'd0);
        check("rst_wstrb", 64'(s_wstrb), 64'd0);
        check("rst_err", 64'(wlast_err), 64'd0);
        check("rst_err_id", 64'(err_id), 64'd0);
        check("rst_wready", 64'(dsp_wready), 64'hF);
        check("rst_stall", 64'(aw_stall), 64'd0);

        // Single master, single burst of 4
        clear_mon();
        aw_push(1, 3);
        send_beat(1, 32'hA0, 1'b0, hs0);
        send_beat(1, 32'hA1, 1'b0, hs);
        send_beat(1, 32'hA2, 1'b0, hs);
        send_beat(1, 32'hA3, 1'b1, hs);
        wait_beats(4, "single");
        check("single_first_latency", 64'(mon_cyc[0]), 64'(hs0 + 1));
        for (int k = 0; k < 4; k++) begin
            check("single_data", 64'(mon_data[k]), 64'(32'hA0 + k));
            check("single_strb", 64'(mon_strb[k]), 64'hF);
            check("single_last", 64'(mon_last[k]), 64'(k == 3));
            check("single_cycle", 64'(mon_cyc[k]), 64'(mon_cyc[0] + k));
        end

        // Ordering: master 2 granted first, master 0 data arrives first
        clear_mon();
        aw_push(2, 0);
        aw_push(0, 1);
        send_beat(0, 32'hB0, 1'b0, hs);
        send_beat(0, 32'hB1, 1'b1, hs);
        send_beat(2, 32'hC0, 1'b1, hs);
        wait_beats(3, "order");
        check("order_d0", 64'(mon_data[0]), 64'hC0);
        check("order_d1", 64'(mon_data[1]), 64'hB0);
        check("order_d2", 64'(mon_data[2]), 64'hB1);
        check("order_l0", 64'(mon_last[0]), 64'd1);
        check("order_l1", 64'(mon_last[1]), 64'd0);
        check("order_l2", 64'(mon_last[2]), 64'd1);

        // Back-to-back bursts, data queued before the AW entries
        clear_mon();
        send_beat(0, 32'hD0, 1'b0, hs);
        send_beat(0, 32'hD1, 1'b1, hs);
        send_beat(1, 32'hE0, 1'b0, hs);
        send_beat(1, 32'hE1, 1'b1, hs);
        check("b2b_no_early_beat", 64'(mon_data.size()), 64'd0);
        aw_push(0, 1);
        aw_m = cyc;
        aw_push(1, 1);
        wait_beats(4, "b2b");
        check("b2b_aw_latency", 64'(mon_cyc[0]), 64'(aw_m + 1));
        for (int k = 0; k < 4; k++) begin
            check("b2b_cycle", 64'(mon_cyc[k]), 64'(mon_cyc[0] + k));
            check("b2b_last", 64'(mon_last[k]), 64'(k == 1 || k == 3));
        end
        check("b2b_d0", 64'(mon_data[0]), 64'hD0);
        check("b2b_d3", 64'(mon_data[3]), 64'hE1);

        // Backpressure for 3 cycles mid-burst
        clear_mon();
        send_beat(2, 32'hF0, 1'b0, hs);
        send_beat(2, 32'hF1, 1'b0, hs);
        send_beat(2, 32'hF2, 1'b0, hs);
        send_beat(2, 32'hF3, 1'b1, hs);
        aw_push(2, 3);
        t = 0;
        while (!(s_wvalid && s_wdata == 32'hF1) && t < 50) begin
            step();
            t++;
        end
        check("bp_reach_beat1", 64'(s_wdata), 64'hF1);
        s_wready = 1'b0;
        held     = s_wdata;
        repeat (3) begin
            step();
            check("bp_hold_valid", 64'(s_wvalid), 64'd1);
            check("bp_hold_data", 64'(s_wdata), 64'(held));
            check("bp_hold_last", 64'(s_wlast), 64'd0);
        end
        s_wready = 1'b1;
        wait_beats(4, "bp");
        for (int k = 0; k < 4; k++) begin
            check("bp_data", 64'(mon_data[k]), 64'(32'hF0 + k));
            check("bp_last", 64'(mon_last[k]), 64'(k == 3));
        end

        // WLAST mismatch: master 3 marks beat 2 of a 3-beat burst as last
        clear_mon();
        aw_push(3, 2);
        send_beat(3, 32'h60, 1'b0, hs);
        send_beat(3, 32'h61, 1'b1, hs);
        send_beat(3, 32'h62, 1'b0, hs);
        wait_beats(3, "wlerr");
        for (int k = 0; k < 3; k++) begin
            check("wlerr_data", 64'(mon_data[k]), 64'(32'h60 + k));
            check("wlerr_last", 64'(mon_last[k]), 64'(k == 2));
        end
        check("wlerr_pulses", 64'(err_ids.size()), 64'd2);
        check("wlerr_id0", 64'(err_ids[0]), 64'd3);
        check("wlerr_id1", 64'(err_ids[1]), 64'd3);
        check("wlerr_when", 64'(err_cyc[0]), 64'(mon_cyc[1]));
        check("wlerr_consec", 64'(err_cyc[1]), 64'(err_cyc[0] + 1));
        check("wlerr_idle", 64'(wlast_err), 64'd0);
        check("wlerr_id_held", 64'(err_id), 64'd3);

        // Queue 3 fills with no AW entry for it
        clear_mon();
        for (int k = 0; k < 16; k++) send_beat(3, 32'h300 + k, 1'b0, hs);
        check("qfull_wready3", 64'(dsp_wready[3]), 64'd0);
        check("qfull_others", 64'(dsp_wready[2:0]), 64'h7);
        check("qfull_no_beat", 64'(mon_data.size()), 64'd0);

        // Order FIFO full: 8 entries accepted, the 9th dropped
        for (int k = 0; k < 7; k++) aw_push(0, 0);
        check("ofull_not_yet", 64'(aw_stall), 64'd0);
        aw_push(0, 0);
        check("ofull_stall", 64'(aw_stall), 64'd1);
        aw_push(1, 0);
        for (int k = 0; k < 8; k++) send_beat(0, 32'h70 + k, 1'b1, hs);
        send_beat(1, 32'h80, 1'b1, hs);
        wait_beats(8, "ofull");
        check("ofull_last_data", 64'(mon_data[7]), 64'h77);
        check("ofull_stall_clear", 64'(aw_stall), 64'd0);

        // Reset after 2 of 4 beats
        clear_mon();
        aw_push(2, 3);
        send_beat(2, 32'h90, 1'b0, hs);
        send_beat(2, 32'h91, 1'b0, hs);
        t = 0;
        while (mon_data.size() < 2 && t < 50) begin
            step();
            t++;
        end
        check("rstmid_two_beats", 64'(mon_data.size()), 64'd2);
        rst_n = 1'b0;
        repeat (2) step();
        check("rstmid_wvalid", 64'(s_wvalid), 64'd0);
        check("rstmid_wlast", 64'(s_wlast), 64'd0);
        check("rstmid_wdata", 64'(s_wdata), 64'd0);
        check("rstmid_wstrb", 64'(s_wstrb), 64'd0);
        check("rstmid_err_id", 64'(err_id), 64'd0);
        check("rstmid_wready", 64'(dsp_wready), 64'hF);
        check("rstmid_stall", 64'(aw_stall), 64'd0);
        rst_n = 1'b1;
        step();
        clear_mon();
        send_beat(2, 32'h92, 1'b0, hs);
        aw_push(2, 0);
        wait_beats(1, "post_rst");
        check("post_rst_data", 64'(mon_data[0]), 64'h92);
        check("post_rst_last", 64'(mon_last[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sa_wdata_steer.md
# sa_wdata_steer

Next-generation slave-side write-data steering block for the AXI4 interconnect, one instance per slave port. It queues per-master write beats, including WDATA, WSTRB and WLAST, from the dispatchers. It forwards them to the slave strictly in AW-grant order, using an order FIFO of {master ID, AxLEN} written by the AW channel. Compared with the previous generation it adds:
- WSTRB transport;
- 8-bit AxLEN;
- a configurable per-master queue depth;
- gap-free back-to-back bursts;
- detection of WLAST mismatches.

## Interface
Parameters:
- MST_AMT, 4: number of masters (≥2).
- MST_ID_W, $clog2(MST_AMT): master ID width.
- OUTSTANDING_AMT, 8: order FIFO depth (power of 2).
- WDATA_FIFO_DEPTH, 16: per-master beat queue depth (power of 2).
- DATA_WIDTH, 32: WDATA width (multiple of 8).
- STRB_WIDTH, DATA_WIDTH/8: WSTRB width.
- TRANS_DATA_LEN_W, 8: AxLEN width.

Ports:
- ACLK_i  in  1  clock; all logic on rising edge.
- ARESETn_i  in  1  reset; synchronous, active-low.
- dsp_WDATA_i  in  DATA_WIDTH*MST_AMT  per-master write data; slice i belongs to master i.
- dsp_WSTRB_i  in  STRB_WIDTH*MST_AMT  per-master strobes.
- dsp_WLAST_i  in  MST_AMT  per-master WLAST.
- dsp_WVALID_i  in  MST_AMT  per-master WVALID.
- dsp_slv_sel_i  in  MST_AMT  bit i high when master i's beat targets this slave.
- dsp_WREADY_o  out  MST_AMT  bit i = queue i not full.
- AW_mst_id_i  in  MST_ID_W  granted master ID.
- AW_AxLEN_i  in  TRANS_DATA_LEN_W  granted AWLEN.
- AW_fifo_order_wr_en_i  in  1  push {AW_mst_id_i, AW_AxLEN_i} into the order FIFO.
- AW_stall_o  out  1  order FIFO full.
- s_WDATA_o  out  DATA_WIDTH  slave write data.
- s_WSTRB_o  out  STRB_WIDTH  slave strobes.
- s_WLAST_o  out  1  slave WLAST.
- s_WVALID_o  out  1  slave WVALID.
- s_WREADY_i  in  1  slave WREADY.
- wlast_err_o  out  1  one-cycle pulse on a WLAST mismatch.
- wlast_err_id_o  out  MST_ID_W  offending master; held until the next pulse.

## Operation
- Enqueue: master i's beat is written into queue i when dsp_WVALID_i[i] & dsp_slv_sel_i[i] & dsp_WREADY_o[i]. The queue entry is {WDATA, WSTRB, WLAST}.
- Order push: happens when AW_fifo_order_wr_en_i & ~AW_stall_o. A push while full is dropped; the AW channel must honour the stall.
- Head: the order FIFO head gives the active master H and length L. The beat counter cnt (TRANS_DATA_LEN_W bits) counts beats issued in the current burst.
- Output register: one stage holding {WDATA, WSTRB, WLAST, VALID}.
  - out_free = ~s_WVALID_o | s_WREADY_i.
- Issue condition: order FIFO non-empty & queue H non-empty & out_free. When it holds:
  - pop queue H and load the output register with its data and strobe;
  - set s_WLAST_o = (cnt == L), computed from the count, not from the master's WLAST;
  - if cnt == L: pop the order FIFO and set cnt to 0; otherwise cnt + 1.
- Without an issue: if s_WREADY_i is high, the output register clears VALID; otherwise it holds all fields stable.
- WLAST check: at issue, if the stored WLAST ≠ (cnt == L):
  - pulse wlast_err_o the following cycle and load H into wlast_err_id_o;
  - forwarding still follows the counted length.
- Data that arrives before its AW entry stays queued. Beats of a master whose ID is not at the head never block other masters' enqueue.

## Timing
- Reset values: s_WVALID_o, s_WLAST_o, wlast_err_o = 0; s_WDATA_o, s_WSTRB_o, wlast_err_id_o = 0; cnt = 0.
  - All FIFOs are empty, so dsp_WREADY_o = all ones and AW_stall_o = 0.
- Reset asserted mid-burst flushes everything; partial bursts are discarded.
- Latency, with the AW entry already present:
  - dsp handshake at edge N → queue non-empty after N;
  - issue at edge N+1 → s_WVALID_o high in the cycle after N+1.
- Latency when the AW push comes last: AW push at edge M → first beat valid after edge M+1.
- Throughput: one beat per cycle under continuous s_WREADY_i, including across burst boundaries. The WLAST beat of burst k is followed by beat 0 of burst k+1 on the next cycle.
- Backpressure: while s_WVALID_o & ~s_WREADY_i, the outputs are held stable (AXI rule) and nothing is popped.
- Simultaneous pop and push on the same queue or order FIFO are both performed. When a FIFO is full, the push is refused via its ready/stall, with no bypass.
- L = 0 gives a single beat with WLAST; L = 255 gives 256 beats. cnt never wraps within a burst.

## Structure
- Shared interconnect header/package holds:
  - the order-entry layout {mst_id, len};
  - the queue-entry layout {data, strb, last}.
- Reuses the existing generic fifo for the order FIFO and for the MST_AMT per-master queues.
- The output register and counter are in-line; no new sub-module.

## Test plan
- Single master, single burst: AW {id=1, len=3}, master 1 sends 4 beats 0xA0..0xA3 with WSTRB=0xF and WREADY always 1 → s_W beats 0xA0..0xA3 on consecutive cycles, WLAST only on 0xA3, first beat 2 cycles after the first handshake.
- Ordering: AW pushes {2,0} then {0,1}; master 0 data arrives first → slave sees master 2's beat first, then master 0's 2 beats. Master 0 is not back-pressured while its 2 beats fit its queue.
- Back-to-back: AW entries {0,1} and {1,1} queued, both queues filled → 4 beats in 4 consecutive cycles, WLAST on beats 2 and 4.
- Backpressure: s_WREADY_i low for 3 cycles mid-burst → outputs held stable and no beat lost or duplicated. Queue fills at WDATA_FIFO_DEPTH → dsp_WREADY_o drops.
- WLAST mismatch: AW {3,2}, master 3 asserts WLAST on beat 2 → slave gets 3 beats with WLAST on beat 3; wlast_err_o pulses twice (beats 2 and 3) with wlast_err_id_o=3.
- Reset mid-burst / order full: reset after 2 of 4 beats → all outputs 0 and queues empty. OUTSTANDING_AMT pushes without data → AW_stall_o=1 and the extra push is ignored.
